// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
//   Shared widths, memory access type codes and the buffered-store entry
//   layout for the store buffer and its FIFO.
//   No ports (package).
package store_buffer_pkg;

  localparam int CPU_WIDTH             = 32;
  localparam int MEM_ACCESS_TYPE_WIDTH = 4;
  localparam int MEM_STRB_WIDTH        = 4;
  localparam int SB_WADDR_W            = CPU_WIDTH - 2;

  // Access type codes shared with the load write-back path.
  typedef enum logic [MEM_ACCESS_TYPE_WIDTH-1:0] {
    MEM_ACCESS_TYPE_NONE        = 4'd0,
    MEM_ACCESS_TYPE_READ_BYTE   = 4'd1,
    MEM_ACCESS_TYPE_READ_HALF   = 4'd2,
    MEM_ACCESS_TYPE_READ_WORD   = 4'd3,
    MEM_ACCESS_TYPE_READ_BYTE_U = 4'd4,
    MEM_ACCESS_TYPE_READ_HALF_U = 4'd5,
    MEM_ACCESS_TYPE_WRITE_BYTE  = 4'd6,
    MEM_ACCESS_TYPE_WRITE_HALF  = 4'd7,
    MEM_ACCESS_TYPE_WRITE_WORD  = 4'd8
  } memAccessType_e;

  // Word address sits in the top bits so the FIFO can tap it for the
  // load-hazard compare without knowing the rest of the layout.
  typedef struct packed {
    logic [SB_WADDR_W-1:0]     wordAddr;
    logic [CPU_WIDTH-1:0]      wdata;
    logic [MEM_STRB_WIDTH-1:0] wstrb;
  } sbEntry_t;

  localparam int SB_ENTRY_W = $bits(sbEntry_t);

endpackage

// File: rtl/store_buffer_sb_fifo.sv
// sb_fifo
//   Generic register FIFO with full/empty flags and per-entry valid and tag
//   taps. The tag is the top TAG_W bits of each entry.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     push_i, data_i    enqueue (caller guarantees !full_o)
//     pop_i             dequeue head (caller guarantees !empty_o)
//     full_o, empty_o   occupancy flags
//     head_o            head entry, zero when empty
//     entryValid_o      per-slot occupied flags
//     entryTag_o        per-slot tag bits
module sb_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int WIDTH = 66,
  parameter int TAG_W = 30
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            data_i,
  input  logic                        pop_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [WIDTH-1:0]            head_o,
  output logic [DEPTH-1:0]            entryValid_o,
  output logic [DEPTH-1:0][TAG_W-1:0] entryTag_o
);

  logic [PTR_W:0]             wrPtr_q, wrPtr_d;
  logic [PTR_W:0]             rdPtr_q, rdPtr_d;
  logic [DEPTH-1:0][WIDTH-1:0] storage_q;
  logic [PTR_W:0]             count;

  assign wrPtr_d = push_i ? wrPtr_q + 1'b1 : wrPtr_q;
  assign rdPtr_d = pop_i  ? rdPtr_q + 1'b1 : rdPtr_q;

  // Extra MSB on each pointer distinguishes full from empty; wrap is
  // plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) storage_q[wrPtr_q[PTR_W-1:0]] <= data_i;
  end

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                   (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign count   = wrPtr_q - rdPtr_q;
  assign head_o  = empty_o ? '0 : storage_q[rdPtr_q[PTR_W-1:0]];

  // A slot is occupied when its distance from the read pointer is below
  // the current count.
  always_comb begin
    entryValid_o = '0;
    entryTag_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offset;
      offset          = PTR_W'(i) - rdPtr_q[PTR_W-1:0];
      entryValid_o[i] = ({1'b0, offset} < count);
      entryTag_o[i]   = storage_q[i][WIDTH-1 -: TAG_W];
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
//   Aligns execute-stage stores into word address / lane data / byte strobe,
//   buffers them and drains them to data memory; flags loads that hit a
//   pending store.
//   Ports:
//     clk, rst_n                         clock, asynchronous active-low reset
//     st_valid_i, st_ready_o             store request handshake
//     mem_access_type, st_addr_i,        access type, byte address, rs2 data
//     st_data_i
//     misalign_o                         one-cycle pulse after a misaligned store
//     mem_wen_o, mem_wready_i            write handshake to data memory
//     mem_waddr_o, mem_wdata_o,          head entry: word address, lane data,
//     mem_wstrb_o                        byte enables
//     ld_valid_i, ld_addr_i, ld_hazard_o load overlap check against pending stores
//     sb_empty_o                         buffer empty
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  localparam int SB_PTR_W = $clog2(SB_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             st_valid_i,
  output logic                             st_ready_o,
  input  logic [MEM_ACCESS_TYPE_WIDTH-1:0] mem_access_type,
  input  logic [CPU_WIDTH-1:0]             st_addr_i,
  input  logic [CPU_WIDTH-1:0]             st_data_i,
  output logic                             misalign_o,
  output logic                             mem_wen_o,
  output logic [CPU_WIDTH-1:0]             mem_waddr_o,
  output logic [CPU_WIDTH-1:0]             mem_wdata_o,
  output logic [MEM_STRB_WIDTH-1:0]        mem_wstrb_o,
  input  logic                             mem_wready_i,
  input  logic                             ld_valid_i,
  input  logic [CPU_WIDTH-1:0]             ld_addr_i,
  output logic                             ld_hazard_o,
  output logic                             sb_empty_o
);

  logic                                 full, empty;
  logic                                 accept, isStore, misaligned, push, pop;
  logic                                 misalign_q, misalign_d;
  sbEntry_t                             newEntry, headEntry;
  logic [SB_ENTRY_W-1:0]                headData;
  logic [SB_DEPTH-1:0]                  entryValid;
  logic [SB_DEPTH-1:0][SB_WADDR_W-1:0]  entryAddr;
  logic [SB_DEPTH-1:0]                  entryHit;

  assign st_ready_o = !full;
  assign accept     = st_valid_i && st_ready_o;

  // Lane replication and strobe generation; misaligned half/word stores
  // are flagged here and later dropped instead of enqueued.
  always_comb begin
    isStore           = 1'b0;
    misaligned        = 1'b0;
    newEntry.wordAddr = st_addr_i[CPU_WIDTH-1:2];
    newEntry.wdata    = st_data_i;
    newEntry.wstrb    = 4'b0000;
    case (mem_access_type)
      MEM_ACCESS_TYPE_WRITE_BYTE: begin
        isStore        = 1'b1;
        newEntry.wdata = {4{st_data_i[7:0]}};
        newEntry.wstrb = 4'b0001 << st_addr_i[1:0];
      end
      MEM_ACCESS_TYPE_WRITE_HALF: begin
        isStore        = 1'b1;
        misaligned     = st_addr_i[0];
        newEntry.wdata = {2{st_data_i[15:0]}};
        newEntry.wstrb = st_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      MEM_ACCESS_TYPE_WRITE_WORD: begin
        isStore        = 1'b1;
        misaligned     = (st_addr_i[1:0] != 2'b00);
        newEntry.wdata = st_data_i;
        newEntry.wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  assign push       = accept && isStore && !misaligned;
  assign misalign_d = accept && isStore && misaligned;
  assign pop        = mem_wen_o && mem_wready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign misalign_o = misalign_q;

  sb_fifo #(
    .DEPTH (SB_DEPTH),
    .PTR_W (SB_PTR_W),
    .WIDTH (SB_ENTRY_W),
    .TAG_W (SB_WADDR_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .data_i       (newEntry),
    .pop_i        (pop),
    .full_o       (full),
    .empty_o      (empty),
    .head_o       (headData),
    .entryValid_o (entryValid),
    .entryTag_o   (entryAddr)
  );

  assign headEntry   = headData;
  assign mem_wen_o   = !empty;
  assign mem_waddr_o = {headEntry.wordAddr, 2'b00};
  assign mem_wdata_o = headEntry.wdata;
  assign mem_wstrb_o = headEntry.wstrb;
  assign sb_empty_o  = empty;

  // Word-granular overlap; the head entry still counts while it dequeues.
  always_comb begin
    entryHit = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      entryHit[i] = entryValid[i] &&
                    ({entryAddr[i], 2'b00} == (ld_addr_i & 32'hFFFF_FFFC));
    end
  end

  assign ld_hazard_o = ld_valid_i && (|entryHit);

endmodule
